// File: rtl/dl_pkg.sv
// dl_router shared package: download indices, ROM region map, variant codes,
// load-tracking FSM states and the decoded-region payload.
package dl_pkg;

   localparam int unsigned IDX_W  = 8;
   localparam int unsigned ADDR_W = 25;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned CNT_W  = 16;

   localparam logic [IDX_W-1:0] IDX_ROM = 8'd0;
   localparam logic [IDX_W-1:0] IDX_MOD = 8'd1;
   localparam logic [IDX_W-1:0] IDX_DIP = 8'd254;

   // Region map within the index-0 ROM image (limits are exclusive)
   localparam logic [ADDR_W-1:0] MAIN_LIMIT = 25'h000_8000;
   localparam logic [ADDR_W-1:0] SND_BASE   = 25'h000_E000;
   localparam logic [ADDR_W-1:0] SND_LIMIT  = 25'h000_F000;
   localparam logic [ADDR_W-1:0] WAV_BASE   = 25'h001_0000;
   localparam logic [ADDR_W-1:0] WAV_LIMIT  = 25'h002_0000;

   localparam logic [DATA_W-1:0] MOD_DKJR       = 8'd1;
   localparam logic [DATA_W-1:0] MOD_DK3        = 8'd2;
   localparam logic [DATA_W-1:0] MOD_RADARSCOPE = 8'd3;
   localparam logic [DATA_W-1:0] MOD_PESTPLACE  = 8'd4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SETTLE,
      ST_DONE
   } dl_state_t;

   // Decoded destinations of one ioctl write; dl_hit may coexist with a ROM hit
   typedef struct packed {
      logic main_hit;
      logic snd_hit;
      logic wav_hit;
      logic dl_hit;
      logic mod_hit;
      logic dip_hit;
   } region_t;

endpackage

// File: rtl/dl_router_if.sv
// dl_router bus: ioctl download inputs and all routed outputs.
interface dl_router_if;
   import dl_pkg::*;

   logic                ioctl_download;
   logic                ioctl_wr;
   logic [IDX_W-1:0]    ioctl_index;
   logic [ADDR_W-1:0]   ioctl_addr;
   logic [DATA_W-1:0]   ioctl_dout;

   logic [DATA_W-1:0]   wr_data;
   logic                main_we;
   logic [14:0]         main_addr;
   logic                snd_we;
   logic [11:0]         snd_addr;
   logic                wav_we;
   logic [15:0]         wav_addr;
   logic                dl_wr;
   logic [15:0]         dl_addr;
   logic                mod_dkjr;
   logic                mod_dk3;
   logic                mod_radarscope;
   logic                mod_pestplace;
   logic [63:0]         dip_sw;
   logic                rom_ready;
   logic                core_reset_req;
   logic                short_load;
   logic [CNT_W-1:0]    checksum;

   modport master (
      output ioctl_download, ioctl_wr, ioctl_index, ioctl_addr, ioctl_dout,
      input  wr_data, main_we, main_addr, snd_we, snd_addr, wav_we, wav_addr,
             dl_wr, dl_addr, mod_dkjr, mod_dk3, mod_radarscope, mod_pestplace,
             dip_sw, rom_ready, core_reset_req, short_load, checksum
   );

   modport slave (
      input  ioctl_download, ioctl_wr, ioctl_index, ioctl_addr, ioctl_dout,
      output wr_data, main_we, main_addr, snd_we, snd_addr, wav_we, wav_addr,
             dl_wr, dl_addr, mod_dkjr, mod_dk3, mod_radarscope, mod_pestplace,
             dip_sw, rom_ready, core_reset_req, short_load, checksum
   );

endinterface

// File: rtl/dl_region_decode.sv
// Combinational decode of one ioctl write into its destination regions plus local address.
module dl_region_decode
   import dl_pkg::*;
(
   input  logic              wr_i,
   input  logic [IDX_W-1:0]  index_i,
   input  logic [ADDR_W-1:0] addr_i,
   output region_t           region_o,
   output logic [15:0]       laddr_o
);

   // Region selection; nothing fires without a write strobe
   always_comb begin
      region_o = '0;
      laddr_o  = addr_i[15:0];
      if (wr_i) begin
         if (index_i == IDX_ROM) begin
            region_o.main_hit = (addr_i < MAIN_LIMIT);
            region_o.snd_hit  = (addr_i >= SND_BASE) && (addr_i < SND_LIMIT);
            region_o.wav_hit  = (addr_i >= WAV_BASE) && (addr_i < WAV_LIMIT);
            region_o.dl_hit   = (addr_i[23:16] == 8'h00);
         end else if (index_i == IDX_MOD) begin
            region_o.mod_hit  = 1'b1;
         end else if (index_i == IDX_DIP) begin
            region_o.dip_hit  = (addr_i[24:3] == 22'd0);
         end
      end
   end

endmodule

// File: rtl/dl_router.sv
// dl_router: routes ioctl writes to ROM/DL/mod/DIP destinations and tracks ROM load state.
// Optional feature: define DL_CHECKSUM_EN to build the main-ROM byte-sum checksum.
module dl_router
   import dl_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES  = 16,
   parameter int unsigned MAIN_MIN_BYTES = 16384
) (
   input  logic       clk_sys,
   input  logic       reset,
   dl_router_if.slave bus
);

   localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);

   region_t            region;
   logic [15:0]        laddr;
   logic               dl_q, rise, fall, load_start, count_en;
   dl_state_t          state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [SET_W-1:0]   settle_q, settle_d;
   logic               rom_ready_q, rom_ready_d, short_q, short_d, core_rst_q;
   logic [DATA_W-1:0]  wr_data_q, mod_q;
   logic               main_we_q, snd_we_q, wav_we_q, dl_wr_q;
   logic [14:0]        main_addr_q;
   logic [11:0]        snd_addr_q;
   logic [15:0]        wav_addr_q, dl_addr_q;
   logic [3:0]         flags_q;
   logic [63:0]        dip_q;

   dl_region_decode u_decode (
      .wr_i     (bus.ioctl_wr),
      .index_i  (bus.ioctl_index),
      .addr_i   (bus.ioctl_addr),
      .region_o (region),
      .laddr_o  (laddr)
   );

   assign rise       = bus.ioctl_download & ~dl_q;
   assign fall       = ~bus.ioctl_download & dl_q;
   assign load_start = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && rise &&
                       (bus.ioctl_index == IDX_ROM);
   assign count_en   = (state_q == ST_LOAD) && region.main_hit;

   // Registered strobes, addresses and write data; addresses hold between their strobes
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         wr_data_q   <= '0;
         main_we_q   <= 1'b0;
         snd_we_q    <= 1'b0;
         wav_we_q    <= 1'b0;
         dl_wr_q     <= 1'b0;
         main_addr_q <= '0;
         snd_addr_q  <= '0;
         wav_addr_q  <= '0;
         dl_addr_q   <= '0;
      end else begin
         main_we_q <= region.main_hit;
         snd_we_q  <= region.snd_hit;
         wav_we_q  <= region.wav_hit;
         dl_wr_q   <= region.dl_hit;
         if (|region) wr_data_q <= bus.ioctl_dout;
         if (region.main_hit) main_addr_q <= laddr[14:0];
         if (region.snd_hit)  snd_addr_q  <= laddr[11:0];
         if (region.wav_hit)  wav_addr_q  <= laddr;
         if (region.dl_hit)   dl_addr_q   <= laddr;
      end
   end

   // Variant byte, its flag decode one cycle later, and the DIP bytes
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         mod_q   <= '0;
         flags_q <= '0;
         dip_q   <= '0;
      end else begin
         if (region.mod_hit) mod_q <= bus.ioctl_dout;
         flags_q <= {(mod_q == MOD_DKJR) || (mod_q == MOD_DK3) || (mod_q == MOD_PESTPLACE),
                     (mod_q == MOD_DK3),
                     (mod_q == MOD_RADARSCOPE),
                     (mod_q == MOD_PESTPLACE)};
         if (region.dip_hit) dip_q[{laddr[2:0], 3'b000} +: 8] <= bus.ioctl_dout;
      end
   end

   // Load FSM state and status registers; download edge tracker resets high so a
   // download already active at reset release is not mistaken for a new one
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         dl_q        <= 1'b1;
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         settle_q    <= '0;
         rom_ready_q <= 1'b0;
         short_q     <= 1'b0;
         core_rst_q  <= 1'b1;
      end else begin
         dl_q        <= bus.ioctl_download;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         settle_q    <= settle_d;
         rom_ready_q <= rom_ready_d;
         short_q     <= short_d;
         core_rst_q  <= ~((state_d == ST_DONE) && rom_ready_d);
      end
   end

   // Load FSM next state: count main bytes in LOAD, settle, then judge the image
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      settle_d    = settle_q;
      rom_ready_d = rom_ready_q;
      short_d     = short_q;
      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (load_start) begin
               state_d     = ST_LOAD;
               cnt_d       = '0;
               short_d     = 1'b0;
               rom_ready_d = 1'b0;
            end
         end
         ST_LOAD: begin
            if (count_en && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
            if (fall) begin
               state_d  = ST_SETTLE;
               settle_d = '0;
            end
         end
         ST_SETTLE: begin
            if (settle_q == SETTLE_LAST) begin
               state_d = ST_DONE;
               if (32'(cnt_q) >= 32'(MAIN_MIN_BYTES)) rom_ready_d = 1'b1;
               else                                   short_d     = 1'b1;
            end else begin
               settle_d = settle_q + SET_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

`ifdef DL_CHECKSUM_EN
   logic [CNT_W-1:0] csum_q, csum_d;

   // Checksum next value: cleared on load start, summed over main bytes in LOAD
   always_comb begin
      csum_d = csum_q;
      if (load_start)    csum_d = '0;
      else if (count_en) csum_d = csum_q + CNT_W'(bus.ioctl_dout);
   end

   // Checksum register
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) csum_q <= '0;
      else       csum_q <= csum_d;
   end

   assign bus.checksum = csum_q;
`else
   assign bus.checksum = '0;
`endif

   assign bus.wr_data        = wr_data_q;
   assign bus.main_we        = main_we_q;
   assign bus.main_addr      = main_addr_q;
   assign bus.snd_we         = snd_we_q;
   assign bus.snd_addr       = snd_addr_q;
   assign bus.wav_we         = wav_we_q;
   assign bus.wav_addr       = wav_addr_q;
   assign bus.dl_wr          = dl_wr_q;
   assign bus.dl_addr        = dl_addr_q;
   assign bus.mod_dkjr       = flags_q[3];
   assign bus.mod_dk3        = flags_q[2];
   assign bus.mod_radarscope = flags_q[1];
   assign bus.mod_pestplace  = flags_q[0];
   assign bus.dip_sw         = dip_q;
   assign bus.rom_ready      = rom_ready_q;
   assign bus.short_load     = short_q;
   assign bus.core_reset_req = core_rst_q;

endmodule

// File: tb/tb_dl_router.sv
// Scoreboard bench for dl_router: stimulus pushes expected strobes, a monitor pops and compares.
module tb_dl_router;
   import dl_pkg::*;

   localparam int unsigned SETTLE    = 16;
   localparam int unsigned MIN_BYTES = 16384;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   dl_router_if bus();

   dl_router #(.SETTLE_CYCLES(SETTLE), .MAIN_MIN_BYTES(MIN_BYTES)) dut (
      .clk_sys (clk),
      .reset   (rst),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          main;
      bit          snd;
      bit          wav;
      bit          dl;
      logic [24:0] addr;
      logic [7:0]  data;
   } exp_t;

   exp_t        exp_q[$];
   bit          in_load = 1'b0;
   int unsigned exp_cnt = 0;
   logic [15:0] exp_sum = '0;
   logic [7:0]  dip_m [8];
   logic [7:0]  mod_m = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic logic [3:0] flags_of(input logic [7:0] v);
      return {(v == 8'd1) || (v == 8'd2) || (v == 8'd4), v == 8'd2, v == 8'd3, v == 8'd4};
   endfunction

   function automatic logic [63:0] dip_pack();
      logic [63:0] r;
      for (int n = 0; n < 8; n++) r[8*n +: 8] = dip_m[n];
      return r;
   endfunction

   function automatic logic [15:0] exp_csum();
`ifdef DL_CHECKSUM_EN
      return exp_sum;
`else
      return 16'h0000;
`endif
   endfunction

   // One ioctl write; the reference model predicts its destinations from the region map
   task automatic do_wr(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d,
                        input bit drop_dl);
      exp_t        e;
      int unsigned ai;
      ai     = 32'(a);
      e.main = (idx == 8'd0) && (ai < 32'h8000);
      e.snd  = (idx == 8'd0) && (ai >= 32'hE000) && (ai < 32'hF000);
      e.wav  = (idx == 8'd0) && (ai >= 32'h10000) && (ai < 32'h20000);
      e.dl   = (idx == 8'd0) && (((ai / 65536) % 256) == 0);
      e.addr = a;
      e.data = d;
      if (e.main || e.snd || e.wav || e.dl) exp_q.push_back(e);
      if (in_load && e.main) begin
         if (exp_cnt < 65535) exp_cnt++;
         exp_sum = exp_sum + 16'(d);
      end
      if (idx == 8'd254 && ai < 8) dip_m[ai] = d;
      if (idx == 8'd1) mod_m = d;
      bus.ioctl_wr    = 1'b1;
      bus.ioctl_index = idx;
      bus.ioctl_addr  = a;
      bus.ioctl_dout  = d;
      if (drop_dl) bus.ioctl_download = 1'b0;
      @(posedge clk);
      #1;
      bus.ioctl_wr = 1'b0;
   endtask

   task automatic start_rom_load();
      bus.ioctl_download = 1'b1;
      bus.ioctl_index    = 8'd0;
      @(posedge clk);
      #1;
      in_load = 1'b1;
      exp_cnt = 0;
      exp_sum = '0;
   endtask

   task automatic wait_cycles(input int n);
      for (int i = 0; i < n; i++) @(posedge clk);
      #1;
   endtask

   // Monitor: every cycle with a ROM/DL strobe consumes one expected write
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (bus.main_we || bus.snd_we || bus.wav_we || bus.dl_wr) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_strobe", 64'({bus.main_we, bus.snd_we, bus.wav_we, bus.dl_wr}),
                   64'd0);
            end else begin
               e = exp_q.pop_front();
               chk("strobes", 64'({bus.main_we, bus.snd_we, bus.wav_we, bus.dl_wr}),
                   64'({e.main, e.snd, e.wav, e.dl}));
               chk("wr_data", 64'(bus.wr_data), 64'(e.data));
               if (e.main) chk("main_addr", 64'(bus.main_addr), 64'(e.addr & 25'h7FFF));
               if (e.snd)  chk("snd_addr",  64'(bus.snd_addr),  64'(e.addr & 25'h0FFF));
               if (e.wav)  chk("wav_addr",  64'(bus.wav_addr),  64'(e.addr & 25'hFFFF));
               if (e.dl)   chk("dl_addr",   64'(bus.dl_addr),   64'(e.addr & 25'hFFFF));
            end
         end
      end
   end

   initial begin
      int          first;
      logic [7:0]  v;
      logic [3:0]  old_f;
      logic [24:0] a;

      for (int n = 0; n < 8; n++) dip_m[n] = 8'h00;
      bus.ioctl_download = 1'b0;
      bus.ioctl_wr       = 1'b0;
      bus.ioctl_index    = 8'd0;
      bus.ioctl_addr     = '0;
      bus.ioctl_dout     = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state
      @(negedge clk);
      chk("rst_core_reset_req", 64'(bus.core_reset_req), 64'd1);
      chk("rst_rom_ready", 64'(bus.rom_ready), 64'd0);
      chk("rst_short_load", 64'(bus.short_load), 64'd0);
      chk("rst_strobes", 64'({bus.main_we, bus.snd_we, bus.wav_we, bus.dl_wr}), 64'd0);
      chk("rst_wr_data", 64'(bus.wr_data), 64'd0);
      chk("rst_checksum", 64'(bus.checksum), 64'd0);
      chk("rst_dip_sw", bus.dip_sw, 64'd0);

      // Directed routing of the four region examples
      @(posedge clk);
      #1;
      do_wr(8'd0, 25'h0000000, 8'h5A, 1'b0);
      do_wr(8'd0, 25'h000E123, 8'h5A, 1'b0);
      do_wr(8'd0, 25'h001FF00, 8'h5A, 1'b0);
      do_wr(8'd0, 25'h0008000, 8'h5A, 1'b0);
      wait_cycles(2);

      // Full load, last main byte arriving in the same cycle the download ends
      start_rom_load();
      for (int i = 0; i < 16383; i++) begin
         if (i % 512 == 7)
            do_wr(8'd0, 25'($urandom_range(32'h8000, 32'h1FF_FFFF)), 8'($urandom), 1'b0);
         do_wr(8'd0, 25'(i), 8'h01, 1'b0);
      end
      do_wr(8'd0, 25'h3FFF, 8'h01, 1'b1);
      in_load = 1'b0;
      first = 0;
      for (int k = 1; k <= 40; k++) begin
         if (k > 1) @(posedge clk);
         @(negedge clk);
         if (bus.rom_ready === 1'b1 && first == 0) first = k;
      end
      chk("full_ready_latency", 64'(first), 64'(SETTLE + 1));
      chk("full_rom_ready", 64'(bus.rom_ready), 64'(exp_cnt >= MIN_BYTES));
      chk("full_core_reset_req", 64'(bus.core_reset_req), 64'd0);
      chk("full_short_load", 64'(bus.short_load), 64'd0);
      chk("full_checksum", 64'(bus.checksum), 64'(exp_csum()));

      // Variant flags via an index-1 download (must not disturb the load state)
      @(posedge clk);
      #1;
      bus.ioctl_download = 1'b1;
      bus.ioctl_index    = 8'd1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) begin
         v = (i == 0) ? 8'h04 : 8'($urandom_range(0, 6));
         old_f = flags_of(mod_m);
         do_wr(8'd1, 25'($urandom), v, 1'b0);
         @(negedge clk);
         chk("mod_flags_hold", 64'({bus.mod_dkjr, bus.mod_dk3, bus.mod_radarscope,
                                    bus.mod_pestplace}), 64'(old_f));
         @(negedge clk);
         chk("mod_flags", 64'({bus.mod_dkjr, bus.mod_dk3, bus.mod_radarscope,
                               bus.mod_pestplace}), 64'(flags_of(v)));
         if (i == 0) begin
            chk("mod4_pestplace", 64'(bus.mod_pestplace), 64'd1);
            chk("mod4_dkjr", 64'(bus.mod_dkjr), 64'd1);
         end
      end
      bus.ioctl_download = 1'b0;

      // DIP bytes via an index-254 download, plus ignored indices and addresses
      @(posedge clk);
      #1;
      bus.ioctl_download = 1'b1;
      bus.ioctl_index    = 8'd254;
      @(posedge clk);
      #1;
      do_wr(8'd254, 25'd3, 8'hA5, 1'b0);
      @(negedge clk);
      chk("dip_byte3", 64'(bus.dip_sw[31:24]), 64'hA5);
      do_wr(8'd254, 25'd8, 8'h3C, 1'b0);
      @(negedge clk);
      chk("dip_addr8_ignored", bus.dip_sw, dip_pack());
      for (int i = 0; i < 12; i++) begin
         a = (i % 4 == 3) ? 25'($urandom) : 25'($urandom_range(0, 15));
         do_wr(8'd254, a, 8'($urandom), 1'b0);
         @(negedge clk);
         chk("dip_random", bus.dip_sw, dip_pack());
      end
      for (int i = 0; i < 6; i++)
         do_wr(8'($urandom_range(2, 253)), 25'($urandom), 8'($urandom), 1'b0);
      bus.ioctl_download = 1'b0;
      wait_cycles(3);
      chk("other_idx_rom_ready", 64'(bus.rom_ready), 64'd1);
      chk("other_idx_core_reset", 64'(bus.core_reset_req), 64'd0);

      // Short load from DONE: ready clears on entry, short_load after settling
      start_rom_load();
      @(negedge clk);
      chk("reload_clears_ready", 64'(bus.rom_ready), 64'd0);
      chk("reload_core_reset", 64'(bus.core_reset_req), 64'd1);
      @(posedge clk);
      #1;
      for (int i = 0; i < 256; i++) do_wr(8'd0, 25'(i), 8'($urandom), 1'b0);
      bus.ioctl_download = 1'b0;
      in_load = 1'b0;
      wait_cycles(SETTLE + 8);
      chk("short_short_load", 64'(bus.short_load), 64'(exp_cnt < MIN_BYTES));
      chk("short_rom_ready", 64'(bus.rom_ready), 64'd0);
      chk("short_core_reset", 64'(bus.core_reset_req), 64'd1);
      chk("short_checksum", 64'(bus.checksum), 64'(exp_csum()));

      // Asynchronous reset in the middle of a load
      start_rom_load();
      for (int i = 0; i < 20; i++) do_wr(8'd0, 25'(i), 8'($urandom), 1'b0);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_core_reset_req", 64'(bus.core_reset_req), 64'd1);
      chk("arst_rom_ready", 64'(bus.rom_ready), 64'd0);
      chk("arst_short_load", 64'(bus.short_load), 64'd0);
      chk("arst_checksum", 64'(bus.checksum), 64'd0);
      chk("arst_strobes", 64'({bus.main_we, bus.snd_we, bus.wav_we, bus.dl_wr}), 64'd0);
      chk("arst_wr_data", 64'(bus.wr_data), 64'd0);
      chk("arst_dip_sw", bus.dip_sw, 64'd0);
      chk("arst_flags", 64'({bus.mod_dkjr, bus.mod_dk3, bus.mod_radarscope,
                             bus.mod_pestplace}), 64'd0);
      in_load = 1'b0;
      for (int n = 0; n < 8; n++) dip_m[n] = 8'h00;
      mod_m = '0;

      // Download still active at reset release must not start a load
      @(posedge clk);
      #1;
      rst = 1'b0;
      wait_cycles(4);
      bus.ioctl_download = 1'b0;
      wait_cycles(SETTLE + 8);
      chk("held_dl_no_load", 64'(bus.short_load), 64'd0);
      chk("held_dl_core_reset", 64'(bus.core_reset_req), 64'd1);

      // A fresh rising edge still starts a load from IDLE
      start_rom_load();
      for (int i = 0; i < 4; i++) do_wr(8'd0, 25'(i), 8'($urandom), 1'b0);
      bus.ioctl_download = 1'b0;
      in_load = 1'b0;
      wait_cycles(SETTLE + 8);
      chk("post_reset_short_load", 64'(bus.short_load), 64'd1);
      chk("post_reset_checksum", 64'(bus.checksum), 64'(exp_csum()));

      wait_cycles(3);
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
